conv_mac_sequencer: RTL and testbench
=====================================

Name: conv_mac_sequencer

Overview:
- Drives one MultAccum-style multiply-accumulate unit for a single KxK convolution window.
- Holds a KxK signed kernel register file. Accepts a window of KxK signed pixels on a valid/ready stream.
- Clears the accumulator, then issues one x/y operand pair per clock. After the MAC pipeline drains, it captures the 32-bit accumulator value and presents it on a valid/ready result port.

Parameters:
- K, 3, kernel/window edge length; N = K*K taps.
- MAC_LAT, 1, cycles (>=1) from an operand pair on x/y until LocalReg reflects it.
- AW, 4, kernel address width; must satisfy 2^AW >= N.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- KWrEn  input  1  kernel write strobe
- KWrAddr  input  AW  kernel tap index, raster order
- KWrData  input  8  signed kernel weight
- PixValid  input  1  pixel stream valid
- PixReady  output  1  pixel stream ready
- PixData  input  8  signed pixel, raster order within window
- x  output  8  signed operand to MAC (pixel)
- y  output  8  signed operand to MAC (weight)
- AccumReset  output  1  accumulator clear to MAC
- LocalReg  input  32  MAC accumulator value
- Result  output  32  captured signed dot product
- ResultValid  output  1  result valid
- ResultReady  input  1  result accepted
- Busy  output  1  high in CLEAR, FEED, DRAIN

Behaviour:
- Reset values:
  - state LOAD; x=0, y=0; AccumReset=1 while Reset is high, 0 after.
  - Result=0, ResultValid=0, PixReady=0 during reset; window and kernel registers cleared to 0; tap counter 0.
- The MAC has no enable. x and y are 0 in every state except FEED, so idle cycles add 0.
- LOAD:
  - PixReady=1.
  - Each PixValid&PixReady edge writes PixData to window[cnt] and increments cnt.
  - The edge accepting tap N-1 resets cnt to 0 and goes to CLEAR.
- CLEAR (1 cycle): AccumReset=1, x=y=0. Goes to FEED.
- FEED (N cycles, cnt 0..N-1):
  - x=window[cnt], y=kernel[cnt], AccumReset=0; registered outputs, one pair per clock.
  - After cnt=N-1, go to DRAIN.
- DRAIN (MAC_LAT cycles): x=y=0.
  - On the final DRAIN edge, Result<=LocalReg, ResultValid<=1, go to HOLD.
- HOLD:
  - ResultValid=1 and Result stable until ResultValid&ResultReady. That edge clears ResultValid and goes to LOAD.
  - PixReady=0 in HOLD.
- Latency: ResultValid rises exactly 1+N+MAC_LAT cycles after the edge that accepted the last pixel.
- Kernel writes:
  - Accepted in LOAD and HOLD only; ignored in CLEAR, FEED, DRAIN so weights are stable during a window.
  - KWrAddr >= N is ignored.
  - A KWrEn in the same cycle as the last pixel acceptance is still applied.
- Arithmetic: performed by the MAC as signed 8x8->16, sign-extended to 32. The sequencer does no arithmetic on Result other than the optional clamp below.
- Reset asserted mid-operation (any state): immediate return to reset values. The partially loaded window is discarded; the kernel is cleared. AccumReset=1 during reset also clears the MAC.
- Busy = state in {CLEAR, FEED, DRAIN}.

Optional Feature:
- Macro CONV_RESULT_RELU_EN.
- Defined: at the capture edge, Result <= (LocalReg[31] ? 0 : LocalReg), giving ReLU on output.
- Undefined: Result <= LocalReg unmodified. Ports and timing are identical in both builds.

Test Plan:
1. Kernel all +1, pixels 1..9, ResultReady=1 -> Result=45 (0x0000002D). ResultValid rises 11 cycles after the last pixel edge (K=3, MAC_LAT=1).
2. Kernel all -1, pixels all 127 -> Result=0xFFFFFB89 (-1143). With CONV_RESULT_RELU_EN -> 0x00000000.
3. Kernel all -128, pixels all -128 -> Result=0x00024000 (147456). Two back-to-back windows give identical results, proving CLEAR isolates windows.
4. Hold ResultReady=0 for 5 cycles in HOLD -> Result and ResultValid stable, PixReady=0. A KWrEn to tap 4 in HOLD takes effect on the next window only.
5. KWrEn during FEED (tap 0 := 5) with kernel all 1, pixels 1..9 -> Result=45, write ignored. The next window is also 45 because tap 0 is unchanged.
6. Assert Reset at FEED cnt=4 -> x=y=0, AccumReset=1, ResultValid=0 immediately. After release, PixReady=1 and a fresh window computes correctly with the kernel cleared (Result=0).

Source files
------------

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: streams one KxK pixel window and a KxK kernel into an external MAC, one tap per clock.
// Build option: define CONV_RESULT_RELU_EN to clamp negative dot products to zero at capture.
module conv_mac_sequencer #(
    parameter int K       = 3,
    parameter int MAC_LAT = 1,
    parameter int AW      = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          KWrEn,
    input  logic [AW-1:0] KWrAddr,
    input  logic [7:0]    KWrData,
    input  logic          PixValid,
    output logic          PixReady,
    input  logic [7:0]    PixData,
    output logic [7:0]    x,
    output logic [7:0]    y,
    output logic          AccumReset,
    input  logic [31:0]   LocalReg,
    output logic [31:0]   Result,
    output logic          ResultValid,
    input  logic          ResultReady,
    output logic          Busy
);
    localparam int N  = K * K;
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW-1:0] LastTap   = AW'(N - 1);
    localparam logic [DW-1:0] LastDrain = DW'(MAC_LAT - 1);

    typedef enum logic [2:0] {LOAD, CLEAR, FEED, DRAIN, HOLD} stateT;

    stateT         state, nextState;
    logic [AW-1:0] cnt;
    logic [AW-1:0] nextTap;
    logic [DW-1:0] drainCnt;
    logic [7:0]    window [N];
    logic [7:0]    kernel [N];
    logic          pixFire;
    logic          kernWrOk;
    logic          capture;
    logic [31:0]   capValue;

    assign pixFire  = (state == LOAD) && PixValid;
    assign kernWrOk = KWrEn && ((state == LOAD) || (state == HOLD))
                      && ({1'b0, KWrAddr} < (AW + 1)'(N));
    assign capture  = (state == DRAIN) && (drainCnt == LastDrain);
    assign nextTap  = cnt + AW'(1);

`ifdef CONV_RESULT_RELU_EN
    assign capValue = LocalReg[31] ? 32'd0 : LocalReg;
`else
    assign capValue = LocalReg;
`endif

    // NOTE: clocked state uses <= so every flop updates from pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= LOAD;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            LOAD:    if (pixFire && cnt == LastTap) nextState = CLEAR;
            CLEAR:   nextState = FEED;
            FEED:    if (cnt == LastTap) nextState = DRAIN;
            DRAIN:   if (drainCnt == LastDrain) nextState = HOLD;
            HOLD:    if (ResultValid && ResultReady) nextState = LOAD;
            default: nextState = LOAD;
        endcase
    end

    // NOTE: every output gets a default before any condition so no path leaves it unassigned (no latch).
    always_comb begin
        PixReady   = 1'b0;
        AccumReset = Reset;
        Busy       = 1'b0;
        case (state)
            LOAD:    PixReady = !Reset;
            CLEAR:   begin AccumReset = 1'b1; Busy = 1'b1; end
            FEED:    Busy = 1'b1;
            DRAIN:   Busy = 1'b1;
            default: ;
        endcase
    end

    // Tap counter is shared by LOAD (write index) and FEED (read index); both wrap at the last tap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            drainCnt <= '0;
        end else begin
            if (pixFire || state == FEED)
                cnt <= (cnt == LastTap) ? '0 : nextTap;
            if (state == DRAIN)
                drainCnt <= (drainCnt == LastDrain) ? '0 : drainCnt + DW'(1);
        end
    end

    // NOTE: window and kernel are flops rather than RAM so they can be reset; a reset must discard both.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                window[i] <= '0;
                kernel[i] <= '0;
            end
        end else begin
            if (pixFire)  window[cnt]     <= PixData;
            if (kernWrOk) kernel[KWrAddr] <= KWrData;
        end
    end

    // Operands are registered one tap ahead so the pair for cnt is on x/y throughout that FEED cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= '0;
            y <= '0;
            if (state == CLEAR) begin
                x <= window[0];
                y <= kernel[0];
            end else if (state == FEED && cnt != LastTap) begin
                x <= window[nextTap];
                y <= kernel[nextTap];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Result      <= '0;
            ResultValid <= 1'b0;
        end else if (capture) begin
            Result      <= capValue;
            ResultValid <= 1'b1;
        end else if (ResultValid && ResultReady) begin
            ResultValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Testbench for conv_mac_sequencer: behavioural MAC plus a dot-product reference model over random and directed windows.
module tb_conv_mac_sequencer;
    localparam int K       = 3;
    localparam int MAC_LAT = 1;
    localparam int AW      = 4;
    localparam int N       = K * K;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          KWrEn = 1'b0;
    logic [AW-1:0] KWrAddr = '0;
    logic [7:0]    KWrData = '0;
    logic          PixValid = 1'b0;
    logic          PixReady;
    logic [7:0]    PixData = '0;
    logic [7:0]    x, y;
    logic          AccumReset;
    logic [31:0]   LocalReg = '0;
    logic [31:0]   Result;
    logic          ResultValid;
    logic          ResultReady = 1'b0;
    logic          Busy;

    int errors = 0;
    int checks = 0;

    logic signed [7:0] pix  [N];
    logic signed [7:0] kern [N];
    logic              lastWrEn = 1'b0;
    logic [AW-1:0]     lastWrAddr = '0;
    logic [7:0]        lastWrData = '0;
    logic [7:0]        holdData = '0;

    conv_mac_sequencer #(.K(K), .MAC_LAT(MAC_LAT), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset),
        .KWrEn(KWrEn), .KWrAddr(KWrAddr), .KWrData(KWrData),
        .PixValid(PixValid), .PixReady(PixReady), .PixData(PixData),
        .x(x), .y(y), .AccumReset(AccumReset), .LocalReg(LocalReg),
        .Result(Result), .ResultValid(ResultValid), .ResultReady(ResultReady),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Single-cycle MAC: signed 8x8 product sign-extended and accumulated.
    logic signed [15:0] prod;
    assign prod = $signed(x) * $signed(y);
    always @(posedge Clk) LocalReg <= AccumReset ? 32'd0 : LocalReg + {{16{prod[15]}}, prod};

    function automatic logic [31:0] refDot();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(pix[i]) * int'(kern[i]);
`ifdef CONV_RESULT_RELU_EN
        if (s < 0) s = 0;
`endif
        return 32'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic writeKernel(input logic [AW-1:0] addr, input logic [7:0] data);
        KWrEn = 1'b1; KWrAddr = addr; KWrData = data;
        tick();
        KWrEn = 1'b0;
        if (int'(addr) < N) kern[addr] = data;
    endtask

    task automatic runWindow(input string name, input int holdCycles, input bit holdWr,
                             input bit feedWr, input bit resetMid);
        logic [31:0] expRes;
        int lat;
        check({name, "_pixready"}, 32'(PixReady), 32'd1);
        for (int i = 0; i < N; i++) begin
            PixValid = 1'b1;
            PixData  = pix[i];
            if (i == N - 1 && lastWrEn) begin
                KWrEn = 1'b1; KWrAddr = lastWrAddr; KWrData = lastWrData;
            end
            tick();
        end
        PixValid = 1'b0;
        KWrEn    = 1'b0;
        if (lastWrEn && int'(lastWrAddr) < N) kern[lastWrAddr] = lastWrData;
        lastWrEn = 1'b0;
        expRes = refDot();

        lat = 0;
        while (ResultValid !== 1'b1 && lat < 64) begin
            if (lat == 0)
                check({name, "_clear"}, 32'({AccumReset, Busy, x, y}), 32'({2'b11, 16'h0000}));
            else if (lat <= N)
                check({name, "_feed"}, 32'({AccumReset, Busy, x, y}),
                      32'({2'b01, pix[lat-1], kern[lat-1]}));
            else if (lat == N + 1)
                check({name, "_drain"}, 32'({AccumReset, Busy, x, y}), 32'({2'b01, 16'h0000}));
            if (feedWr && lat == 3) begin
                KWrEn = 1'b1; KWrAddr = '0; KWrData = 8'd5;
            end
            if (resetMid && lat == 5) begin
                Reset = 1'b1;
                #1;
                check({name, "_rst_ops"}, 32'({x, y}), 32'd0);
                check({name, "_rst_accum"}, 32'(AccumReset), 32'd1);
                check({name, "_rst_flags"}, 32'({ResultValid, PixReady, Busy}), 32'd0);
                tick();
                Reset = 1'b0;
                #1;
                check({name, "_rst_release"}, 32'({PixReady, Busy}), 32'b10);
                for (int i = 0; i < N; i++) kern[i] = '0;
                return;
            end
            tick();
            KWrEn = 1'b0;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(1 + N + MAC_LAT));
        check({name, "_result"}, Result, expRes);

        for (int h = 0; h < holdCycles; h++) begin
            check({name, "_hold_result"}, Result, expRes);
            check({name, "_hold_flags"}, 32'({ResultValid, PixReady, Busy}), 32'b100);
            if (holdWr && h == 1) begin
                KWrEn = 1'b1; KWrAddr = AW'(4); KWrData = holdData;
            end
            tick();
            KWrEn = 1'b0;
        end
        if (holdWr) kern[4] = holdData;
        ResultReady = 1'b1;
        tick();
        ResultReady = 1'b0;
        check({name, "_accept"}, 32'({ResultValid, PixReady, Busy}), 32'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin pix[i] = '0; kern[i] = '0; end

        // Reset state
        tick(); tick();
        check("rst_ops", 32'({x, y}), 32'd0);
        check("rst_flags", 32'({AccumReset, PixReady, ResultValid, Busy}), 32'b1000);
        check("rst_result", Result, 32'd0);
        Reset = 1'b0;
        #1;
        check("rst_release", 32'({AccumReset, PixReady, Busy}), 32'b010);

        // Kernel +1, pixels 1..9
        for (int i = 0; i < N; i++) begin writeKernel(AW'(i), 8'd1); pix[i] = 8'(i + 1); end
        runWindow("t1", 0, 0, 0, 0);
        check("t1_value", Result, 32'h0000_002D);

        // Kernel -1, pixels 127
        for (int i = 0; i < N; i++) begin writeKernel(AW'(i), 8'hFF); pix[i] = 8'sd127; end
        runWindow("t2", 0, 0, 0, 0);
`ifdef CONV_RESULT_RELU_EN
        check("t2_value", Result, 32'h0000_0000);
`else
        check("t2_value", Result, 32'hFFFF_FB89);
`endif

        // Kernel -128, pixels -128, twice back to back
        for (int i = 0; i < N; i++) begin writeKernel(AW'(i), 8'h80); pix[i] = 8'h80; end
        runWindow("t3a", 0, 0, 0, 0);
        check("t3a_value", Result, 32'h0002_4000);
        runWindow("t3b", 0, 0, 0, 0);
        check("t3b_value", Result, 32'h0002_4000);

        // Hold with ResultReady low, kernel write to tap 4 during HOLD
        for (int i = 0; i < N; i++) begin writeKernel(AW'(i), 8'($urandom)); pix[i] = 8'($urandom); end
        holdData = 8'($urandom_range(1, 127));
        runWindow("t4", 5, 1, 0, 0);
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        runWindow("t4_next", 0, 0, 0, 0);

        // Kernel write during FEED is ignored
        for (int i = 0; i < N; i++) begin writeKernel(AW'(i), 8'd1); pix[i] = 8'(i + 1); end
        runWindow("t5", 0, 0, 1, 0);
        check("t5_value", Result, 32'h0000_002D);
        runWindow("t5_next", 0, 0, 0, 0);
        check("t5_next_value", Result, 32'h0000_002D);

        // Out-of-range writes ignored; write alongside the last pixel applied
        for (int a = N; a < (1 << AW); a++) writeKernel(AW'(a), 8'($urandom));
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        lastWrEn = 1'b1;
        lastWrAddr = AW'($urandom_range(0, N - 1));
        lastWrData = 8'($urandom_range(1, 255));
        runWindow("edge", 0, 0, 0, 0);

        // Random windows with partial kernel rewrites
        for (int w = 0; w < 6; w++) begin
            for (int j = 0; j < 3; j++) writeKernel(AW'($urandom_range(0, N - 1)), 8'($urandom));
            for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
            runWindow("rand", int'($urandom_range(0, 3)), 0, 0, 0);
        end

        // Reset at FEED cnt=4, then a fresh window against a cleared kernel
        for (int i = 0; i < N; i++) begin writeKernel(AW'(i), 8'($urandom_range(1, 127))); pix[i] = 8'($urandom); end
        runWindow("t6", 0, 0, 0, 1);
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom_range(1, 127));
        runWindow("t6_fresh", 0, 0, 0, 0);
        check("t6_fresh_value", Result, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
